// File: rtl/hilo_seq_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer: op codes and FSM states.
package hilo_seq_pkg;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MFHI  = 4'd5,
    OP_MFLO  = 4'd6,
    OP_MTHI  = 4'd7,
    OP_MTLO  = 4'd8
  } hilo_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } hilo_state_e;

  // True for the op codes that launch a multi-cycle arithmetic operation.
  function automatic logic is_arith_op(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/hilo_seq_if.sv
// Bundles the pipeline-facing HI/LO signals; master is the pipeline, slave is the sequencer.
interface hilo_seq_if (input logic clk);

  logic        op_valid;
  logic [3:0]  op;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        d_is_md;
  logic        start;
  logic        busy;
  logic        stall_req;
  logic [31:0] rd_out;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    input  clk,
    output op_valid, op, rs, rt, d_is_md,
    input  start, busy, stall_req, rd_out, hi, lo
  );

  modport slave (
    input  clk,
    input  op_valid, op, rs, rt, d_is_md,
    output start, busy, stall_req, rd_out, hi, lo
  );

endinterface

// File: rtl/hilo_seq_arith.sv
// Purely combinational MULT/MULTU/DIV/DIVU datapath producing the HI/LO result pair.
module hilo_arith
  import hilo_seq_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic [31:0] hi_res,
  output logic [31:0] lo_res,
  output logic        div0
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] rt_safe;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] q_s;
  logic [31:0] r_s;

  // Products, plus a sign-magnitude signed divide so MIN/-1 wraps cleanly to MIN with remainder 0.
  always_comb begin
    prod_s  = $signed({{32{rs[31]}}, rs}) * $signed({{32{rt[31]}}, rt});
    prod_u  = {32'd0, rs} * {32'd0, rt};
    rt_safe = (rt == 32'd0) ? 32'd1 : rt;
    abs_a   = rs[31] ? (~rs + 32'd1) : rs;
    abs_b   = rt_safe[31] ? (~rt_safe + 32'd1) : rt_safe;
    q_mag   = abs_a / abs_b;
    r_mag   = abs_a % abs_b;
    q_s     = (rs[31] ^ rt_safe[31]) ? (~q_mag + 32'd1) : q_mag;
    r_s     = rs[31] ? (~r_mag + 32'd1) : r_mag;
  end

  // Select the result pair for the requested op; non-arithmetic ops yield zero.
  always_comb begin
    hi_res = 32'd0;
    lo_res = 32'd0;
    div0   = 1'b0;
    case (op)
      OP_MULT:  {hi_res, lo_res} = prod_s;
      OP_MULTU: {hi_res, lo_res} = prod_u;
      OP_DIV: begin
        lo_res = q_s;
        hi_res = r_s;
        div0   = (rt == 32'd0);
      end
      OP_DIVU: begin
        lo_res = rs / rt_safe;
        hi_res = rs % rt_safe;
        div0   = (rt == 32'd0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/hilo_seq.sv
// HI/LO sequencer: accepts MULT/DIV ops, holds busy for a fixed latency, then commits HI/LO.
module hilo_seq
  import hilo_seq_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [3:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic        d_is_md,
  output logic        start,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] rd_out,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  hilo_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] hi_res_q, hi_res_d;
  logic [31:0] lo_res_q, lo_res_d;
  logic        div0_q, div0_d;

  logic [31:0] arith_hi;
  logic [31:0] arith_lo;
  logic        arith_div0;

  hilo_arith u_arith (
    .op     (op),
    .rs     (rs),
    .rt     (rt),
    .hi_res (arith_hi),
    .lo_res (arith_lo),
    .div0   (arith_div0)
  );

  // Pipeline-facing decode: acceptance, stall request and committed-value read port.
  always_comb begin
    start     = op_valid & ~busy_q & is_arith_op(op);
    stall_req = d_is_md & (busy_q | start);
    rd_out    = 32'd0;
    if (op == OP_MFHI) rd_out = hi_q;
    else if (op == OP_MFLO) rd_out = lo_q;
  end

  // Next-state logic: launch on start, count down while busy, commit when the counter hits zero.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    hi_res_d = hi_res_q;
    lo_res_d = lo_res_q;
    div0_d   = div0_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          hi_res_d = arith_hi;
          lo_res_d = arith_lo;
          div0_d   = arith_div0;
          busy_d   = 1'b1;
          if ((op == OP_MULT) || (op == OP_MULTU)) begin
            state_d = ST_MUL;
            cnt_d   = CNT_W'(MULT_CYCLES - 1);
          end else begin
            state_d = ST_DIV;
            cnt_d   = CNT_W'(DIV_CYCLES - 1);
          end
        end else if (op_valid && (op == OP_MTHI)) begin
          hi_d = rs;
        end else if (op_valid && (op == OP_MTLO)) begin
          lo_d = rs;
        end
      end
      ST_MUL, ST_DIV: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          if (!div0_q) begin
            hi_d = hi_res_q;
            lo_d = lo_res_q;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // FSM state register; a low reset aborts any in-flight op without committing.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      hi_res_q <= 32'd0;
      lo_res_q <= 32'd0;
      div0_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      hi_res_q <= hi_res_d;
      lo_res_q <= lo_res_d;
      div0_q   <= div0_d;
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
